draw_scheduler: RTL and testbench
=================================

// Module: draw_scheduler
// PURPOSE
//  Owns the single VGA-adapter plot port (160x120, 3-bit colour) and shares it between NCLIENT drawing engines
//  (fillscreen, circle, ...), each speaking the level start/done protocol. Accepts per-client draw requests,
//  grants one engine at a time (round-robin), drives its start, muxes its plot stream to the adapter,
//  sequences the done/release handshake and guards against hung engines with a watchdog.
// PARAMETERS
//  NCLIENT   3        number of requester/engine pairs (2..8)
//  WDOG_MAX  200000   cycles an engine may run before forced abort (> 19200 fillscreen pixels + margin)
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            asynchronous, active-low reset
//  req          in   NCLIENT      level draw request per client; held until matching ack
//  ack          out  NCLIENT      1-cycle pulse: job of client i finished (normal or aborted)
//  abort        out  NCLIENT      1-cycle pulse with ack when job ended by watchdog
//  busy         out  1            high whenever an engine is granted
//  grant        out  NCLIENT      one-hot, current owner of plot port; 0 when idle
//  eng_start    out  NCLIENT      start to engine i (level)
//  eng_done     in   NCLIENT      done from engine i
//  eng_x        in   NCLIENT*8    engine i x, packed [i*8 +: 8]
//  eng_y        in   NCLIENT*7    engine i y, packed [i*7 +: 7]
//  eng_colour   in   NCLIENT*3    engine i colour, packed [i*3 +: 3]
//  eng_plot     in   NCLIENT      engine i plot strobe
//  vga_x        out  8            to adapter
//  vga_y        out  7            to adapter
//  vga_colour   out  3            to adapter
//  vga_plot     out  1            to adapter
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0; RR pointer = client 0; watchdog = 0. Reset mid-job drops
//    eng_start immediately; no ack issued for the interrupted job.
//  - States: IDLE -> RUN -> RELEASE -> IDLE.
//    IDLE: if any req, pick first requester at/after RR pointer; next cycle grant[i]=1, eng_start[i]=1, busy=1, state RUN.
//    RUN: mux engine i outputs combinationally to vga_*; vga_plot = eng_plot[i] & grant[i] & x<160 & y<120
//      (out-of-range pixels suppressed, x/y/colour still passed). On eng_done[i]=1: eng_start[i]<=0, state RELEASE.
//      If watchdog reaches WDOG_MAX-1 first: eng_start[i]<=0, set abort flag, state RELEASE.
//    RELEASE: vga_plot forced 0. When eng_done[i]=0 (or 1 cycle after an abort): ack[i] pulse (abort[i] too if
//      aborted), grant<=0, busy<=0, RR pointer <= i+1 mod NCLIENT, state IDLE.
//  - Latency: req rise in IDLE -> eng_start 1 cycle; eng_done -> eng_start low 1 cycle; min idle gap between jobs
//    is 1 cycle (IDLE re-arbitrates the cycle after ack).
//  - Watchdog: counts cycles in RUN, clears on entry to RUN; width $clog2(WDOG_MAX).
//  - Requests that drop before grant are ignored; req held by the owner during RUN has no effect; ack only
//    for the granted client. Simultaneous requests: round-robin, strictly fair.
//  - vga_x/y/colour = 0 when no grant; vga_plot never high outside RUN.
// STRUCTURE
//  - draw_pkg: SCREEN_W=160, SCREEN_H=120, typedefs xcoord_t (8b), ycoord_t (7b), colour_t (3b),
//    sched_state_e {IDLE, RUN, RELEASE}.
//  - Sub-module rr_arbiter #(N): req + pointer -> one-hot grant, combinational; registered by draw_scheduler.
//  - Output mux and range check inline.
// TESTING
//  1 Reset: hold rst_n=0 with req=3'b111 -> grant=0, eng_start=0, vga_plot=0, busy=0.
//  2 Single job: req=3'b001, model fillscreen on port 0 -> eng_start[0] next cycle; 19200 vga_plot pulses
//    pass through with matching x/y/colour; eng_done -> eng_start low; ack[0] pulse once done drops.
//  3 Round-robin: req=3'b111 held, engines finish after 10 cycles -> grant order 001,010,100,001; one idle
//    cycle between jobs; no two grant bits ever high.
//  4 Range guard: granted engine plots x=160,y=5 and x=3,y=120 -> vga_plot=0 both; x=159,y=119 -> vga_plot=1.
//  5 Watchdog: WDOG_MAX=50, engine never raises done -> eng_start drops at cycle 50, ack[i] & abort[i] pulse,
//    next requester granted.
//  6 Reset mid-job: assert rst_n=0 during RUN -> eng_start/vga_plot low asynchronously, no ack; after release,
//    pending req re-granted starting from client 0.

Source files
------------

// File: rtl/draw_scheduler_pkg.sv
// draw_pkg: shared screen geometry, pixel field types and scheduler state
// encoding for the draw scheduler slice.
package draw_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef logic [7:0] xcoord_t;
  typedef logic [6:0] ycoord_t;
  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RELEASE
  } sched_state_e;

  // True when the pixel lies inside the visible 160x120 area.
  function automatic logic on_screen(input xcoord_t x, input ycoord_t y);
    return (x < xcoord_t'(SCREEN_W)) && (y < ycoord_t'(SCREEN_H));
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: bundle of client request/ack, engine start/done/plot
// streams and the single VGA-adapter plot port.
//   master modport : the scheduler (drives ack/abort/busy/grant/eng_start/vga_*)
//   slave modport  : clients, engines and adapter (drive req/eng_*)
// Packed engine buses: eng_x[i*8 +: 8], eng_y[i*7 +: 7], eng_colour[i*3 +: 3].
interface draw_scheduler_if #(
  parameter int unsigned NCLIENT = 3
);
  import draw_pkg::*;

  logic [NCLIENT-1:0]   req;
  logic [NCLIENT-1:0]   ack;
  logic [NCLIENT-1:0]   abort;
  logic                 busy;
  logic [NCLIENT-1:0]   grant;
  logic [NCLIENT-1:0]   eng_start;
  logic [NCLIENT-1:0]   eng_done;
  logic [NCLIENT*8-1:0] eng_x;
  logic [NCLIENT*7-1:0] eng_y;
  logic [NCLIENT*3-1:0] eng_colour;
  logic [NCLIENT-1:0]   eng_plot;
  xcoord_t              vga_x;
  ycoord_t              vga_y;
  colour_t              vga_colour;
  logic                 vga_plot;

  modport master (
    input  req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
    output ack, abort, busy, grant, eng_start,
           vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    output req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
    input  ack, abort, busy, grant, eng_start,
           vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/draw_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Scans requesters starting at
// ptr_i and wrapping; returns the first one as a one-hot grant plus its index.
//   req_i   : request vector
//   ptr_i   : highest-priority client this round
//   gnt_o   : one-hot grant (all zero when no request)
//   idx_o   : index of the granted client
//   valid_o : any request present
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: owns the VGA-adapter plot port and shares it between
// NCLIENT drawing engines. One engine is granted at a time (round-robin),
// its start is driven, its plot stream is muxed to the adapter with an
// on-screen guard, and the done/release handshake is sequenced. A watchdog
// aborts engines that run for WDOG_MAX cycles without finishing.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : draw_scheduler_if master modport (client req/ack/abort,
//                busy/grant, engine start/done/pixel streams, vga_* port)
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned NCLIENT  = 3,
  parameter int unsigned WDOG_MAX = 200000
) (
  input  logic                clk,
  input  logic                rst_n,
  draw_scheduler_if.master    bus
);

  localparam int unsigned IDX_W  = $clog2(NCLIENT);
  localparam int unsigned WDOG_W = $clog2(WDOG_MAX);

  sched_state_e       state_q, state_d;
  logic [NCLIENT-1:0] grant_q, start_q;
  logic [IDX_W-1:0]   owner_q, ptr_q;
  logic [WDOG_W-1:0]  wdog_q;
  logic               abort_q;

  logic [NCLIENT-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  xcoord_t own_x;
  ycoord_t own_y;
  colour_t own_col;
  logic    own_plot, own_done;
  logic    wdog_hit, rel_fire;

  rr_arbiter #(.N(NCLIENT), .IDX_W(IDX_W)) u_arb (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // One-hot mux on the registered grant; all fields read as zero when idle.
  always_comb begin
    own_x    = '0;
    own_y    = '0;
    own_col  = '0;
    own_plot = 1'b0;
    own_done = 1'b0;
    for (int unsigned i = 0; i < NCLIENT; i++) begin
      if (grant_q[i]) begin
        own_x    = bus.eng_x[i*8 +: 8];
        own_y    = bus.eng_y[i*7 +: 7];
        own_col  = bus.eng_colour[i*3 +: 3];
        own_plot = bus.eng_plot[i];
        own_done = bus.eng_done[i];
      end
    end
  end

  assign wdog_hit = (wdog_q == WDOG_W'(WDOG_MAX - 1));
  // An aborted engine may never lower done, so release does not wait for it.
  assign rel_fire = (state_q == RELEASE) && (!own_done || abort_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_valid)             state_d = RUN;
      RUN:     if (own_done || wdog_hit)  state_d = RELEASE;
      RELEASE: if (rel_fire)              state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      start_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_gnt;
            start_q <= arb_gnt;
            owner_q <= arb_idx;
            wdog_q  <= '0;
            abort_q <= 1'b0;
          end
        end
        RUN: begin
          wdog_q <= wdog_q + 1'b1;
          // A done arriving on the expiry cycle counts as a normal finish.
          if (own_done) begin
            start_q <= '0;
          end else if (wdog_hit) begin
            start_q <= '0;
            abort_q <= 1'b1;
          end
        end
        RELEASE: begin
          if (rel_fire) begin
            grant_q <= '0;
            abort_q <= 1'b0;
            ptr_q   <= (owner_q == IDX_W'(NCLIENT - 1)) ? '0 : owner_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.grant      = grant_q;
    bus.eng_start  = start_q;
    bus.busy       = |grant_q;
    bus.ack        = rel_fire ? grant_q : '0;
    bus.abort      = (rel_fire && abort_q) ? grant_q : '0;
    bus.vga_x      = own_x;
    bus.vga_y      = own_y;
    bus.vga_colour = own_col;
    bus.vga_plot   = (state_q == RUN) && own_plot && on_screen(own_x, own_y);
  end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;
  import draw_pkg::*;

  localparam int unsigned NC = 3;
  localparam int unsigned WD = 20000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [NC-1:0] req_v;
  int            ptr_m;

  draw_scheduler_if #(.NCLIENT(NC)) bus ();

  draw_scheduler #(.NCLIENT(NC), .WDOG_MAX(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] onehot(input int w);
    logic [NC-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: first pending client at or after the pointer.
  function automatic int pick(input logic [NC-1:0] r, input int p);
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (p + k) % NC;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic rand_engines();
    for (int i = 0; i < NC; i++) begin
      bus.eng_x[i*8 +: 8]      = 8'($urandom_range(0, 175));
      bus.eng_y[i*7 +: 7]      = 7'($urandom_range(0, 127));
      bus.eng_colour[i*3 +: 3] = 3'($urandom);
      bus.eng_plot[i]          = 1'($urandom);
      bus.eng_done[i]          = 1'($urandom);
    end
  endtask

  task automatic check_mux(input int w, input bit run, input string tag);
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
    x = bus.eng_x[w*8 +: 8];
    y = bus.eng_y[w*7 +: 7];
    c = bus.eng_colour[w*3 +: 3];
    p = run && bus.eng_plot[w] && (int'(x) < 160) && (int'(y) < 120);
    chk(tag, 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}), 32'({p, x, y, c}));
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    rand_engines();
    bus.req = req_v;
    #1;
    chk({tag, "_grant"}, 32'(bus.grant), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_start"}, 32'(bus.eng_start), 0);
    chk({tag, "_ack"}, 32'(bus.ack), 0);
    chk({tag, "_vga"}, 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
  endtask

  task automatic run_cycles(input int w, input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      rand_engines();
      bus.eng_done[w] = 1'b0;
      bus.req = req_v;
      #1;
      chk({tag, "_grant"}, 32'(bus.grant), 32'(onehot(w)));
      chk({tag, "_start"}, 32'(bus.eng_start), 32'(onehot(w)));
      chk({tag, "_busy"}, 32'(bus.busy), 1);
      chk({tag, "_ack"}, 32'(bus.ack), 0);
      check_mux(w, 1'b1, {tag, "_vga"});
    end
  endtask

  task automatic finish_job(input int w, input int hold, input bit keep_req);
    @(negedge clk);
    rand_engines();
    bus.eng_done[w] = 1'b1;
    #1;
    chk("done_edge_start", 32'(bus.eng_start), 32'(onehot(w)));
    check_mux(w, 1'b1, "done_edge_vga");
    repeat (hold) begin
      @(negedge clk);
      rand_engines();
      bus.eng_done[w] = 1'b1;
      #1;
      chk("rel_start", 32'(bus.eng_start), 0);
      chk("rel_grant", 32'(bus.grant), 32'(onehot(w)));
      chk("rel_ack", 32'(bus.ack), 0);
      check_mux(w, 1'b0, "rel_vga");
    end
    @(negedge clk);
    rand_engines();
    bus.eng_done[w] = 1'b0;
    #1;
    chk("ack_pulse", 32'(bus.ack), 32'(onehot(w)));
    chk("ack_abort", 32'(bus.abort), 0);
    chk("ack_start", 32'(bus.eng_start), 0);
    check_mux(w, 1'b0, "ack_vga");
    ptr_m = (w + 1) % NC;
    if (!keep_req) req_v[w] = 1'b0;
  endtask

  initial begin
    int w, w2, pix;
    int rx[4];
    int ry[4];
    int rp[4];
    logic [NC-1:0] rr_exp[4];

    req_v = '0;
    ptr_m = 0;
    rand_engines();
    bus.req = '1;
    rst_n = 1'b0;

    // Reset with every client requesting.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_start", 32'(bus.eng_start), 0);
    chk("rst_plot", 32'(bus.vga_plot), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_abort", 32'(bus.abort), 0);
    @(negedge clk);
    bus.req = '0;
    rst_n = 1'b1;

    // Round-robin with all requests held, 10-cycle jobs.
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    req_v = '1;
    for (int j = 0; j < 4; j++) begin
      idle_cycle("rr_idle");
      w = pick(req_v, ptr_m);
      run_cycles(w, 1, "rr_first");
      chk("rr_order", 32'(bus.grant), 32'(rr_exp[j]));
      run_cycles(w, 9, "rr_run");
      finish_job(w, 1, 1'b1);
    end

    // Fillscreen on client 0: every pixel of the screen passes through.
    req_v = 3'b001;
    idle_cycle("fill_idle");
    w = pick(req_v, ptr_m);
    pix = 0;
    for (int x = 0; x < 160; x++) begin
      for (int y = 0; y < 120; y++) begin
        @(negedge clk);
        rand_engines();
        bus.eng_x[7:0]      = 8'(x);
        bus.eng_y[6:0]      = 7'(y);
        bus.eng_colour[2:0] = 3'(x + y);
        bus.eng_plot[0]     = 1'b1;
        bus.eng_done[0]     = 1'b0;
        bus.req = req_v;
        #1;
        if (bus.vga_plot === 1'b1) pix++;
        chk("fill_pix", 32'({bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour}),
            32'({1'b1, 8'(x), 7'(y), 3'(x + y)}));
      end
    end
    chk("fill_count", 32'(pix), 19200);
    chk("fill_start", 32'(bus.eng_start), 32'(onehot(w)));
    finish_job(w, 2, 1'b0);

    // Range guard on the edges of the screen.
    rx[0] = 160; ry[0] = 5;   rp[0] = 0;
    rx[1] = 3;   ry[1] = 120; rp[1] = 0;
    rx[2] = 159; ry[2] = 119; rp[2] = 1;
    rx[3] = 0;   ry[3] = 0;   rp[3] = 1;
    req_v = 3'b010;
    idle_cycle("range_idle");
    w = pick(req_v, ptr_m);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rand_engines();
      bus.eng_x[w*8 +: 8] = 8'(rx[k]);
      bus.eng_y[w*7 +: 7] = 7'(ry[k]);
      bus.eng_plot[w]     = 1'b1;
      bus.eng_done[w]     = 1'b0;
      #1;
      chk("range_plot", 32'(bus.vga_plot), 32'(rp[k]));
      chk("range_xy", 32'({bus.vga_x, bus.vga_y}), 32'({8'(rx[k]), 7'(ry[k])}));
    end
    finish_job(w, 1, 1'b0);

    // Random request mixes, job lengths and done-hold times.
    for (int it = 0; it < 12; it++) begin
      req_v = req_v | 3'($urandom_range(1, 7));
      idle_cycle("rnd_idle");
      w = pick(req_v, ptr_m);
      run_cycles(w, $urandom_range(1, 30), "rnd_run");
      finish_job(w, $urandom_range(0, 3), 1'b0);
    end

    // Watchdog: engine never finishes.
    req_v = '1;
    idle_cycle("wd_idle");
    w = pick(req_v, ptr_m);
    run_cycles(w, WD, "wd_run");
    @(negedge clk);
    rand_engines();
    bus.eng_done[w] = 1'b0;
    #1;
    chk("wd_start", 32'(bus.eng_start), 0);
    chk("wd_ack", 32'(bus.ack), 32'(onehot(w)));
    chk("wd_abort", 32'(bus.abort), 32'(onehot(w)));
    check_mux(w, 1'b0, "wd_vga");
    ptr_m = (w + 1) % NC;
    req_v[w] = 1'b0;
    idle_cycle("wd_next_idle");
    w2 = pick(req_v, ptr_m);
    run_cycles(w2, 3, "wd_next_run");
    finish_job(w2, 1, 1'b0);

    // Reset mid-job: pointer must restart at client 0.
    req_v = 3'b010;
    idle_cycle("mr_pre_idle");
    w = pick(req_v, ptr_m);
    run_cycles(w, 2, "mr_pre_run");
    finish_job(w, 1, 1'b0);
    req_v = 3'b101;
    idle_cycle("mr_idle");
    w = pick(req_v, ptr_m);
    chk("mr_owner", 32'(w), 2);
    run_cycles(w, 5, "mr_run");
    @(negedge clk);
    rand_engines();
    bus.eng_plot = '1;
    rst_n = 1'b0;
    #1;
    chk("mr_start", 32'(bus.eng_start), 0);
    chk("mr_grant", 32'(bus.grant), 0);
    chk("mr_plot", 32'(bus.vga_plot), 0);
    chk("mr_ack", 32'(bus.ack), 0);
    chk("mr_busy", 32'(bus.busy), 0);
    repeat (2) begin
      @(negedge clk);
      rand_engines();
      #1;
      chk("mr_hold_ack", 32'(bus.ack), 0);
    end
    ptr_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rand_engines();
    #1;
    chk("mr_rel_grant", 32'(bus.grant), 0);
    w = pick(req_v, ptr_m);
    run_cycles(w, 1, "mr_regrant");
    chk("mr_regrant_id", 32'(bus.grant), 32'(3'b001));
    run_cycles(w, 2, "mr_regrant_run");
    finish_job(w, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
